// File: rtl/riscv_mdu_iter.sv
// riscv_mdu_iter: RV32M/RV64M multiply/divide unit with one op in flight.
// Multiplier with configurable latency, 1-bit/cycle restoring divider and a fast path for special divides.
`default_nettype none

module riscv_mdu_iter #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       funct3,
    input  logic             is_32bit,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_ITER, S_DIV_FIX, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = 32; i < XLEN; i++) r[i] = x[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mul_res(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                input logic [1:0] f, input logic w);
        logic [2*XLEN-1:0] ea, eb, p;
        logic sa, sb;
        sa = (f == 2'b01 || f == 2'b10) ? a[XLEN-1] : 1'b0;
        sb = (f == 2'b01) ? b[XLEN-1] : 1'b0;
        ea = {{XLEN{sa}}, a};
        eb = {{XLEN{sb}}, b};
        p  = ea * eb;
        if (f == 2'b00) return w ? sext32(p[XLEN-1:0]) : p[XLEN-1:0];
        return p[2*XLEN-1:XLEN];
    endfunction

    state_t state, state_nx;

    logic [XLEN-1:0]  a_reg, b_reg, q_reg, r_reg, d_reg;
    logic [1:0]       f_reg;
    logic             w_reg, negq_reg, negr_reg, rem_reg;
    logic [6:0]       cnt, last;
    logic [TAG_W-1:0] tag_reg;

    // Request-side decode, evaluated on the raw operands at accept time.
    logic            accept, wop, is_div, sgn, is_rem, div0, ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, special_res;

    assign req_ready  = (state == S_IDLE) && !rst;
    assign accept     = req_valid && req_ready && !flush;
    assign resp_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign resp_tag   = tag_reg;

    assign wop    = (XLEN > 32) && is_32bit;
    assign is_div = funct3[2];
    assign sgn    = !funct3[0];
    assign is_rem = funct3[1];
    assign a_ext  = wop ? (sgn ? sext32(rs1_data) : {{(XLEN-32){1'b0}}, rs1_data[31:0]}) : rs1_data;
    assign b_ext  = wop ? (sgn ? sext32(rs2_data) : {{(XLEN-32){1'b0}}, rs2_data[31:0]}) : rs2_data;
    assign mag_a  = (sgn && a_ext[XLEN-1]) ? -a_ext : a_ext;
    assign mag_b  = (sgn && b_ext[XLEN-1]) ? -b_ext : b_ext;
    assign div0   = (b_ext == '0);
    assign ovf    = sgn && (b_ext == '1) &&
                    (wop ? (rs1_data[31:0] == 32'h8000_0000) : (rs1_data == MIN_NEG));
    assign special = div0 || ovf;

    always_comb begin
        special_res = '0;
        if (div0)        special_res = is_rem ? (wop ? sext32(rs1_data) : rs1_data) : '1;
        else if (!is_rem) special_res = wop ? sext32(rs1_data) : rs1_data;
    end

    // Restoring step: shift the next dividend bit into the partial remainder.
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] q_fix, r_fix, fix_res;
    assign shifted = {r_reg, q_reg[XLEN-1]};
    assign diff    = shifted - {1'b0, d_reg};
    assign q_fix   = negq_reg ? -q_reg : q_reg;
    assign r_fix   = negr_reg ? -r_reg : r_reg;
    assign fix_res = w_reg ? sext32(rem_reg ? r_fix : q_fix) : (rem_reg ? r_fix : q_fix);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) begin
                if (!is_div)      state_nx = (MUL_LAT == 1) ? S_DONE : S_MUL;
                else if (special) state_nx = S_DONE;
                else              state_nx = S_DIV_ITER;
            end
            S_MUL:      if (cnt == 7'(MUL_LAT - 2)) state_nx = S_DONE;
            S_DIV_ITER: if (cnt == last) state_nx = S_DIV_FIX;
            S_DIV_FIX:  state_nx = S_DONE;
            S_DONE:     if (resp_ready) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0; b_reg <= '0; q_reg <= '0; r_reg <= '0; d_reg <= '0;
            f_reg <= '0; w_reg <= 1'b0; negq_reg <= 1'b0; negr_reg <= 1'b0; rem_reg <= 1'b0;
            cnt <= '0; last <= '0; tag_reg <= '0; resp_data <= '0;
        end else if (accept) begin
            a_reg    <= rs1_data;
            b_reg    <= rs2_data;
            f_reg    <= funct3[1:0];
            w_reg    <= wop;
            tag_reg  <= req_tag;
            cnt      <= '0;
            last     <= (wop || XLEN == 32) ? 7'd31 : 7'(XLEN - 1);
            // W dividends sit in the top half so the first iterations consume their MSBs.
            q_reg    <= wop ? (mag_a << (XLEN - 32)) : mag_a;
            r_reg    <= '0;
            d_reg    <= mag_b;
            negq_reg <= sgn && (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
            negr_reg <= sgn && a_ext[XLEN-1];
            rem_reg  <= is_rem;
            if (is_div && special)            resp_data <= special_res;
            else if (!is_div && MUL_LAT == 1) resp_data <= mul_res(rs1_data, rs2_data, funct3[1:0], wop);
        end else begin
            case (state)
                S_MUL: begin
                    cnt <= cnt + 7'd1;
                    if (cnt == 7'(MUL_LAT - 2)) resp_data <= mul_res(a_reg, b_reg, f_reg, w_reg);
                end
                S_DIV_ITER: begin
                    cnt   <= cnt + 7'd1;
                    r_reg <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                    q_reg <= {q_reg[XLEN-2:0], !diff[XLEN]};
                end
                S_DIV_FIX: resp_data <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_mdu_iter.sv
// Directed self-checking bench for riscv_mdu_iter (XLEN=64, MUL_LAT=2).
`default_nettype none

module tb_riscv_mdu_iter;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, is_32bit, resp_valid, resp_ready, busy;
    logic [2:0]  funct3;
    logic [63:0] rs1_data, rs2_data, resp_data;
    logic [4:0]  req_tag, resp_tag;

    int errors = 0;
    int checks = 0;

    riscv_mdu_iter #(.XLEN(64), .MUL_LAT(2), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .is_32bit(is_32bit),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag);
        @(negedge clk);
        chk("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        funct3 = f3; is_32bit = w; rs1_data = a; rs2_data = b; req_tag = tag; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("idle_after_take", {63'd0, busy}, 64'd0);
    endtask

    task automatic run(input string name, input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp, input int exp_lat);
        int lat;
        issue(f3, w, a, b, tag);
        wait_resp(lat);
        chk({name, "_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({name, "_data"}, resp_data, exp);
        chk({name, "_tag"}, {59'd0, resp_tag}, {59'd0, tag});
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        take();
    endtask

    initial begin
        int lat;
        logic [63:0] held_data;
        logic [4:0]  held_tag;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        funct3 = 3'd0; is_32bit = 1'b0; rs1_data = '0; rs2_data = '0; req_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_tag", {59'd0, resp_tag}, 64'd0);
        rst = 1'b0;

        run("mul",     3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        run("mulhu",   3'b011, 1'b0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        run("mulhsu",  3'b010, 1'b0, '1, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run("mulh",    3'b001, 1'b0, '1, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run("mulw",    3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        run("div0",    3'b100, 1'b0, 64'd7, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("rem0",    3'b110, 1'b0, 64'd7, 64'd0, 5'd7, 64'd7, 1);
        run("divovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd8, 64'h8000_0000_0000_0000, 1);
        run("remwovf", 3'b110, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd9, 64'd0, 1);
        run("divuw",   3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run("divw",    3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run("div_neg", 3'b100, 1'b0, -64'sd7, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run("rem_neg", 3'b110, 1'b0, -64'sd7, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run("remu",    3'b111, 1'b0, 64'd100, 64'd7, 5'd14, 64'd2, 66);

        // Consumer stalls: held result must not move and no new request may enter.
        issue(3'b101, 1'b0, 64'd100, 64'd7, 5'd21);
        wait_resp(lat);
        chk("stall_lat", 64'(lat), 64'd66);
        held_data = resp_data;
        held_tag  = resp_tag;
        chk("stall_data", held_data, 64'd14);
        @(negedge clk);
        funct3 = 3'b000; rs1_data = 64'd3; rs2_data = 64'd3; req_tag = 5'd30; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, resp_valid}, 64'd1);
            chk("stall_hold_data", resp_data, 64'd14);
            chk("stall_hold_tag", {59'd0, resp_tag}, 64'd21);
            chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        take();

        // Flush in the middle of a 64-bit divide; a simultaneous request is ignored.
        issue(3'b100, 1'b0, 64'd1000, 64'd3, 5'd15);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; funct3 = 3'b000; rs1_data = 64'd5; rs2_data = 64'd5;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_valid", {63'd0, resp_valid}, 64'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (resp_valid) seen++;
            end
            chk("flush_no_resp", 64'(seen), 64'd0);
        end
        run("div_after_flush", 3'b100, 1'b0, 64'd100, 64'd7, 5'd16, 64'd14, 66);

        // Reset while iterating.
        issue(3'b100, 1'b0, 64'd1000, 64'd3, 5'd17);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_data", resp_data, 64'd0);
        chk("midrst_tag", {59'd0, resp_tag}, 64'd0);
        chk("midrst_req_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
        run("div_after_rst", 3'b100, 1'b0, 64'd1000, 64'd3, 5'd18, 64'd333, 66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
